// File: rtl/pulse_amp_multi_ch_addr_sequencer_pkg.sv
// Shared definitions for the multi-channel pulse amplitude-memory address sequencer.
//   - default widths for channel count, direction (bank select) and full address
//   - per-channel FSM state encoding
// Optional feature macro: PULSE_AMP_ADDR_MIRROR_EN adds the DOWN state (mirrored ramp).
package pulse_amp_multi_ch_addr_sequencer_pkg;

  localparam int unsigned DEF_NUM_CH                = 4;
  localparam int unsigned DEF_DIRECTION_WIDTH       = 2;
  localparam int unsigned DEF_AMP_MEMORY_ADDR_WIDTH = 9;
  localparam int unsigned DEF_COUNTER_WIDTH         =
      DEF_AMP_MEMORY_ADDR_WIDTH - DEF_DIRECTION_WIDTH;

`ifdef PULSE_AMP_ADDR_MIRROR_EN
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDown = 2'd2
  } ch_state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1
  } ch_state_e;
`endif

endpackage

// File: rtl/pulse_amp_multi_ch_addr_sequencer_if.sv
// Request/response bundle between the pulse-circuit instruction decoder (master) and the
// address sequencer (slave).
//   sample_tick          global advance strobe
//   start/abort          per-channel start/restart and stop requests
//   direction_in         per-channel direction, packed, channel i at [i*DIRECTION_WIDTH +: ...]
//   length_in            per-channel sample count, packed
//   mirror_in            per-channel mirror request (only used with PULSE_AMP_ADDR_MIRROR_EN)
//   amp_memory_addr_out  per-channel {dir, count}, packed
//   addr_valid/done      per-channel busy flag and one-cycle completion pulse
interface pulse_amp_multi_ch_addr_sequencer_if
  import pulse_amp_multi_ch_addr_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH                = DEF_NUM_CH,
  parameter int unsigned DIRECTION_WIDTH       = DEF_DIRECTION_WIDTH,
  parameter int unsigned AMP_MEMORY_ADDR_WIDTH = DEF_AMP_MEMORY_ADDR_WIDTH
);
  localparam int unsigned COUNTER_WIDTH = AMP_MEMORY_ADDR_WIDTH - DIRECTION_WIDTH;

  logic                                      sample_tick;
  logic [NUM_CH-1:0]                         start;
  logic [NUM_CH-1:0]                         abort;
  logic [NUM_CH*DIRECTION_WIDTH-1:0]         direction_in;
  logic [NUM_CH*COUNTER_WIDTH-1:0]           length_in;
  logic [NUM_CH-1:0]                         mirror_in;
  logic [NUM_CH*AMP_MEMORY_ADDR_WIDTH-1:0]   amp_memory_addr_out;
  logic [NUM_CH-1:0]                         addr_valid;
  logic [NUM_CH-1:0]                         done;

  modport master (
    output sample_tick, start, abort, direction_in, length_in, mirror_in,
    input  amp_memory_addr_out, addr_valid, done
  );

  modport slave (
    input  sample_tick, start, abort, direction_in, length_in, mirror_in,
    output amp_memory_addr_out, addr_valid, done
  );

endinterface

// File: rtl/pulse_amp_multi_ch_addr_sequencer_channel.sv
// One sequencer channel: start-triggered, length-bounded address counter.
//   clk, rst            clock, synchronous active-high reset
//   sample_tick         advance strobe
//   start, abort        restart / stop requests (start has priority)
//   direction_in        direction latched on start (address MSBs)
//   length_in           number of samples latched on start (0 = immediate done)
//   mirror_in           mirror request, present only with PULSE_AMP_ADDR_MIRROR_EN
//   amp_memory_addr_out {dir_q, count_q}
//   addr_valid          channel busy, address live
//   done                one-cycle pulse after the last sample was consumed
// With PULSE_AMP_ADDR_MIRROR_EN a mirrored sequence ramps up then back down, repeating the
// top sample once, for 2*len samples in total.
module pulse_amp_multi_ch_addr_sequencer_channel
  import pulse_amp_multi_ch_addr_sequencer_pkg::*;
#(
  parameter int unsigned DIRECTION_WIDTH = DEF_DIRECTION_WIDTH,
  parameter int unsigned COUNTER_WIDTH   = DEF_COUNTER_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     sample_tick,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [DIRECTION_WIDTH-1:0]               direction_in,
  input  logic [COUNTER_WIDTH-1:0]                 length_in,
`ifdef PULSE_AMP_ADDR_MIRROR_EN
  input  logic                                     mirror_in,
`endif
  output logic [DIRECTION_WIDTH+COUNTER_WIDTH-1:0] amp_memory_addr_out,
  output logic                                     addr_valid,
  output logic                                     done
);

  ch_state_e                  state_q;
  logic [DIRECTION_WIDTH-1:0] dir_q;
  logic [COUNTER_WIDTH-1:0]   count_q;
  logic [COUNTER_WIDTH-1:0]   len_q;
  logic                       valid_q;
  logic                       done_q;
`ifdef PULSE_AMP_ADDR_MIRROR_EN
  logic                       mirror_q;
`endif

  // Only evaluated in StUp, where len_q is known to be non-zero.
  logic last_up;
  assign last_up = (count_q == (len_q - COUNTER_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      dir_q    <= '0;
      count_q  <= '0;
      len_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef PULSE_AMP_ADDR_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // Restart from any state; an interrupted sequence never reports done.
        dir_q   <= direction_in;
        len_q   <= length_in;
        count_q <= '0;
`ifdef PULSE_AMP_ADDR_MIRROR_EN
        mirror_q <= mirror_in;
`endif
        if (length_in == '0) begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= StUp;
          valid_q <= 1'b1;
        end
      end else if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        count_q <= '0;
      end else if (sample_tick) begin
        case (state_q)
          StUp: begin
            if (!last_up) begin
              count_q <= count_q + COUNTER_WIDTH'(1);
`ifdef PULSE_AMP_ADDR_MIRROR_EN
            end else if (mirror_q) begin
              // Top sample is repeated once: count holds on entry to StDown.
              state_q <= StDown;
`endif
            end else begin
              state_q <= StIdle;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`ifdef PULSE_AMP_ADDR_MIRROR_EN
          StDown: begin
            if (count_q == '0) begin
              state_q <= StIdle;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              count_q <= count_q - COUNTER_WIDTH'(1);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign amp_memory_addr_out = {dir_q, count_q};
  assign addr_valid          = valid_q;
  assign done                = done_q;

endmodule

// File: rtl/pulse_amp_multi_ch_addr_sequencer.sv
// Multi-channel pulse amplitude-memory address sequencer, one channel per drive line.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   slave side of pulse_amp_multi_ch_addr_sequencer_if carrying the shared sample_tick,
//         per-channel requests and per-channel {dir, count} addresses / valid / done
// Channel i occupies bits [i*W +: W] of every packed per-channel field.
// Optional feature macro: PULSE_AMP_ADDR_MIRROR_EN (mirrored up/down ramps); when undefined
// mirror_in is ignored.
module pulse_amp_multi_ch_addr_sequencer
  import pulse_amp_multi_ch_addr_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH                = DEF_NUM_CH,
  parameter int unsigned DIRECTION_WIDTH       = DEF_DIRECTION_WIDTH,
  parameter int unsigned AMP_MEMORY_ADDR_WIDTH = DEF_AMP_MEMORY_ADDR_WIDTH
) (
  input logic                               clk,
  input logic                               rst,
  pulse_amp_multi_ch_addr_sequencer_if.slave bus
);

  localparam int unsigned COUNTER_WIDTH = AMP_MEMORY_ADDR_WIDTH - DIRECTION_WIDTH;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_amp_multi_ch_addr_sequencer_channel #(
      .DIRECTION_WIDTH (DIRECTION_WIDTH),
      .COUNTER_WIDTH   (COUNTER_WIDTH)
    ) u_ch (
      .clk                 (clk),
      .rst                 (rst),
      .sample_tick         (bus.sample_tick),
      .start               (bus.start[i]),
      .abort               (bus.abort[i]),
      .direction_in        (bus.direction_in[i*DIRECTION_WIDTH +: DIRECTION_WIDTH]),
      .length_in           (bus.length_in[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
`ifdef PULSE_AMP_ADDR_MIRROR_EN
      .mirror_in           (bus.mirror_in[i]),
`endif
      .amp_memory_addr_out (bus.amp_memory_addr_out[i*AMP_MEMORY_ADDR_WIDTH +:
                                                    AMP_MEMORY_ADDR_WIDTH]),
      .addr_valid          (bus.addr_valid[i]),
      .done                (bus.done[i])
    );
  end

`ifndef PULSE_AMP_ADDR_MIRROR_EN
  logic unused_mirror;
  assign unused_mirror = ^bus.mirror_in;
`endif

endmodule

// File: tb/tb_pulse_amp_multi_ch_addr_sequencer.sv
// Self-checking bench for pulse_amp_multi_ch_addr_sequencer (default 4 ch, 2-bit dir, 9-bit addr).
module tb_pulse_amp_multi_ch_addr_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 2;
  localparam int unsigned AW  = 9;
  localparam int unsigned CW  = AW - DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_amp_multi_ch_addr_sequencer_if #(
    .NUM_CH                (NCH),
    .DIRECTION_WIDTH       (DW),
    .AMP_MEMORY_ADDR_WIDTH (AW)
  ) bus ();

  pulse_amp_multi_ch_addr_sequencer #(
    .NUM_CH                (NCH),
    .DIRECTION_WIDTH       (DW),
    .AMP_MEMORY_ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         ch;
    logic       st;
    logic       ab;
    logic       mir;
    logic [1:0] dir;
    logic [6:0] len;
    logic       tick;
    logic [8:0] e_addr;
    logic [3:0] e_valid;
    logic [3:0] e_done;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(int ch, logic st, logic ab, logic mir, logic [1:0] dir,
                              logic [6:0] len, logic tick, logic [8:0] ea, logic [3:0] ev,
                              logic [3:0] ed);
    vec_t v;
    v.ch = ch; v.st = st; v.ab = ab; v.mir = mir; v.dir = dir; v.len = len; v.tick = tick;
    v.e_addr = ea; v.e_valid = ev; v.e_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.sample_tick  = 1'b0;
    bus.start        = '0;
    bus.abort        = '0;
    bus.mirror_in    = '0;
    bus.direction_in = '0;
    bus.length_in    = '0;
  endtask

  task automatic set_ch(input int ch, input logic st, input logic ab, input logic mir,
                        input logic [1:0] d, input logic [6:0] l);
    bus.start[ch]             = st;
    bus.abort[ch]             = ab;
    bus.mirror_in[ch]         = mir;
    bus.direction_in[ch*DW +: DW] = d;
    bus.length_in[ch*CW +: CW]    = l;
  endtask

  // Inputs are driven on the falling edge; outputs are sampled 1 time unit after the
  // following rising edge.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] addr_of(input int ch);
    logic [NCH*AW-1:0] a;
    a = bus.amp_memory_addr_out;
    return a[ch*AW +: AW];
  endfunction

  // Independence scenario: start edge, length, direction per channel.
  int         ind_s[NCH]   = '{0, 2, 3, 1};
  int         ind_len[NCH] = '{5, 3, 1, 6};
  logic [1:0] ind_dir[NCH] = '{2'd3, 2'd1, 2'd2, 2'd0};

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) edge_sample();
    check("reset_addr",  bus.amp_memory_addr_out, '0);
    check("reset_valid", bus.addr_valid, '0);
    check("reset_done",  bus.done, '0);

    // ---- table: basic ch1 ----
    vecs.push_back(mk(1, 1, 0, 0, 2, 4, 1, 9'h100, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9'h101, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9'h102, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9'h103, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9'h103, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9'h103, 4'b0000, 4'b0000));
    // ---- zero length on ch0, tick in idle ignored ----
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 9'h080, 4'b0000, 4'b0001));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9'h080, 4'b0000, 4'b0000));
    // ---- restart / abort on ch2 ----
    vecs.push_back(mk(2, 1, 0, 0, 3, 10, 0, 9'h180, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h181, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h182, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h183, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h184, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h185, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 1, 0, 0, 3, 10, 1, 9'h180, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h181, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h182, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 1, 0, 0, 0, 1, 9'h180, 4'b0000, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 9'h180, 4'b0000, 4'b0000));
    vecs.push_back(mk(2, 1, 1, 0, 0, 2, 0, 9'h000, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h001, 4'b0100, 4'b0000));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 1, 9'h001, 4'b0000, 4'b0100));
    vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 9'h001, 4'b0000, 4'b0000));
    // ---- mirror request on ch3, len 3 ----
    vecs.push_back(mk(3, 1, 0, 1, 1, 3, 0, 9'h080, 4'b1000, 4'b0000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h081, 4'b1000, 4'b0000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h082, 4'b1000, 4'b0000));
`ifdef PULSE_AMP_ADDR_MIRROR_EN
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h082, 4'b1000, 4'b0000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h081, 4'b1000, 4'b0000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h080, 4'b1000, 4'b0000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h080, 4'b0000, 4'b1000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 9'h080, 4'b0000, 4'b0000));
`else
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h082, 4'b0000, 4'b1000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h082, 4'b0000, 4'b0000));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 9'h082, 4'b0000, 4'b0000));
`endif

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[k]) begin
      @(negedge clk);
      clear_inputs();
      bus.sample_tick = vecs[k].tick;
      set_ch(vecs[k].ch, vecs[k].st, vecs[k].ab, vecs[k].mir, vecs[k].dir, vecs[k].len);
      edge_sample();
      check($sformatf("vec%0d_addr", k),  addr_of(vecs[k].ch), vecs[k].e_addr);
      check($sformatf("vec%0d_valid", k), bus.addr_valid, vecs[k].e_valid);
      check($sformatf("vec%0d_done", k),  bus.done, vecs[k].e_done);
    end

    // ---- maximum length: counter reaches 126 without wrapping ----
    @(negedge clk);
    clear_inputs();
    set_ch(0, 1, 0, 0, 2'd0, 7'd127);
    edge_sample();
    check("maxlen_first", addr_of(0), 9'h000);
    for (int i = 1; i <= 126; i++) begin
      @(negedge clk);
      clear_inputs();
      bus.sample_tick = 1'b1;
      edge_sample();
      check($sformatf("maxlen_cnt%0d", i), addr_of(0), 9'(i));
    end
    check("maxlen_valid", bus.addr_valid, 4'b0001);
    @(negedge clk);
    bus.sample_tick = 1'b1;
    edge_sample();
    check("maxlen_done",  bus.done, 4'b0001);
    check("maxlen_hold",  addr_of(0), 9'h07E);
    check("maxlen_valid_low", bus.addr_valid, 4'b0000);

    // ---- gapped ticks: ch1 len 3, tick every third cycle ----
    @(negedge clk);
    clear_inputs();
    set_ch(1, 1, 0, 0, 2'd1, 7'd3);
    edge_sample();
    check("gap_start", addr_of(1), 9'h080);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      clear_inputs();
      bus.sample_tick = ((k % 3) == 0);
      edge_sample();
      if (k < 9) begin
        check($sformatf("gap_addr%0d", k), addr_of(1), 9'(128 + k / 3));
        check($sformatf("gap_done%0d", k), bus.done, 4'b0000);
      end else begin
        check("gap_final_done",  bus.done, 4'b0010);
        check("gap_final_valid", bus.addr_valid, 4'b0000);
        check("gap_final_addr",  addr_of(1), 9'h082);
      end
    end

    // ---- reset mid-sequence ----
    @(negedge clk);
    clear_inputs();
    set_ch(0, 1, 0, 0, 2'd2, 7'd20);
    set_ch(1, 1, 0, 0, 2'd1, 7'd20);
    edge_sample();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clear_inputs();
      bus.sample_tick = 1'b1;
      edge_sample();
    end
    check("rst_pre_valid", bus.addr_valid, 4'b0011);
    check("rst_pre_addr0", addr_of(0), 9'h103);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.sample_tick = 1'b1;
      edge_sample();
      check($sformatf("rst_mid_addr%0d", k),  bus.amp_memory_addr_out, '0);
      check($sformatf("rst_mid_valid%0d", k), bus.addr_valid, '0);
      check($sformatf("rst_mid_done%0d", k),  bus.done, '0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.sample_tick = 1'b1;
      edge_sample();
      check($sformatf("rst_post_done%0d", k),  bus.done, '0);
      check($sformatf("rst_post_valid%0d", k), bus.addr_valid, '0);
    end

    // ---- independence: staggered starts on all channels, tick every cycle ----
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      clear_inputs();
      bus.sample_tick = 1'b1;
      for (int ch = 0; ch < NCH; ch++)
        if (ind_s[ch] == c) set_ch(ch, 1, 0, 0, ind_dir[ch], 7'(ind_len[ch]));
      edge_sample();
      for (int ch = 0; ch < NCH; ch++) begin
        logic [8:0] ea;
        logic       ev, ed;
        int         rel;
        rel = c - ind_s[ch];
        if (rel < 0) begin
          ea = '0; ev = 1'b0; ed = 1'b0;
        end else if (rel < ind_len[ch]) begin
          ea = {ind_dir[ch], 7'(rel)}; ev = 1'b1; ed = 1'b0;
        end else begin
          ea = {ind_dir[ch], 7'(ind_len[ch] - 1)}; ev = 1'b0; ed = (rel == ind_len[ch]);
        end
        check($sformatf("ind_c%0d_ch%0d_addr", c, ch),  addr_of(ch), ea);
        check($sformatf("ind_c%0d_ch%0d_valid", c, ch), bus.addr_valid[ch], ev);
        check($sformatf("ind_c%0d_ch%0d_done", c, ch),  bus.done[ch], ed);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
